// File: rtl/pipe_stage_reg_if.sv
// rtl/pipe_stage_reg_if.sv - valid/ready/data beat bus between adjacent pipeline stages
//
// Ports (modports):
//   master : drives valid, data; samples ready
//   slave  : samples valid, data; drives ready
// Parameter DATA_W sets the payload width and must match the attached stage.

interface pipe_stage_reg_if #(
    parameter int DATA_W = 96
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (output valid, output data, input  ready);
    modport slave  (input  valid, input  data, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - inter-stage pipeline register with stall, flush and optional skid entry
//
// Carries one payload beat per cycle between two pipeline stages.
// Build option: define PIPE_STAGE_SKID_EN for a two-entry skid buffer whose
// upstream ready is registered (no combinational path from out_ready to in_ready).
// Without it the stage holds a single entry and in_ready depends on out_ready.
//
// Ports:
//   clk           : rising-edge clock
//   rst           : asynchronous active-high reset
//   pipeline_stop : stall, freezes the stage (no accept, no release)
//   flush         : discard held beats, drive BUBBLE_VAL, drop same-cycle input
//   in_bus        : upstream beat (valid/data in, ready out)
//   out_bus       : downstream beat (valid/data out, ready in)
//   occupancy     : number of held beats (0..2 with skid, 0..1 without)

module pipe_stage_reg #(
    parameter int                DATA_W     = 96,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = {DATA_W{1'b0}}
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pipeline_stop,
    input  logic                    flush,
    pipe_stage_reg_if.slave         in_bus,
    pipe_stage_reg_if.master        out_bus,
    output logic [1:0]              occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic              accept;
    logic              rel;

`ifdef PIPE_STAGE_SKID_EN
    logic [DATA_W-1:0] skid_q, skid_d;

    // Ready comes from registered state only, so out_ready never reaches in_ready.
    assign in_bus.ready = !pipeline_stop && !flush && (state_q != FULL);
`else
    // Single entry: the held beat must leave this cycle before a new one lands.
    assign in_bus.ready = !pipeline_stop && !flush && ((state_q == EMPTY) || out_bus.ready);
`endif

    assign accept        = in_bus.valid && in_bus.ready;
    assign rel           = out_bus.valid && out_bus.ready && !pipeline_stop;
    assign out_bus.valid = (state_q != EMPTY);
    assign out_bus.data  = main_q;
    assign occupancy     = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= BUBBLE_VAL;
`ifdef PIPE_STAGE_SKID_EN
            skid_q  <= BUBBLE_VAL;
`endif
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
`ifdef PIPE_STAGE_SKID_EN
            skid_q  <= skid_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
`ifdef PIPE_STAGE_SKID_EN
        skid_d  = skid_q;
`endif
        if (flush) begin
            state_d = EMPTY;
            main_d  = BUBBLE_VAL;
`ifdef PIPE_STAGE_SKID_EN
            skid_d  = BUBBLE_VAL;
`endif
        end else if (!pipeline_stop) begin
            // main_q is left untouched when draining so out_data keeps the
            // last released value while out_valid is low.
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = ONE;
                        main_d  = in_bus.data;
                    end
                end
                ONE: begin
`ifdef PIPE_STAGE_SKID_EN
                    if (accept && rel) begin
                        main_d = in_bus.data;
                    end else if (accept) begin
                        state_d = FULL;
                        skid_d  = in_bus.data;
                    end else if (rel) begin
                        state_d = EMPTY;
                    end
`else
                    // accept in ONE implies out_ready, hence a same-cycle release
                    if (accept) begin
                        main_d = in_bus.data;
                    end else if (rel) begin
                        state_d = EMPTY;
                    end
`endif
                end
`ifdef PIPE_STAGE_SKID_EN
                FULL: begin
                    if (rel) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
`endif
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

endmodule
